// File: rtl/tick_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tick_debouncer
// Purpose  : Debounces a raw mechanical switch using the periodic single-cycle
//            m_tick strobe as its time base. A level change is accepted only
//            after the sampled input has stayed stable for CONFIRM_TICKS
//            strobes. Produces a registered debounced level and a one-cycle
//            pulse on every accepted 0->1 transition.
// Ports    : clock    - system clock, rising edge
//            reset    - asynchronous, active-high reset
//            m_tick   - single-cycle strobe from the tick generator
//            sw       - raw switch input
//            db_level - debounced level (registered)
//            db_tick  - one-cycle pulse on accepted rising transition
// Options  : TICK_DEBOUNCER_SYNC_EN - when defined, sw passes through a
//            2-flop synchronizer; otherwise sw must already be synchronous.
// Revision : 1.0 - initial release
// ============================================================================
module tick_debouncer #(
   parameter int CONFIRM_TICKS = 3,
   parameter int CNT_W         = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic m_tick,
   input  logic sw,
   output logic db_level,
   output logic db_tick
);

   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM_TICKS - 1);

   logic             sw_s;
   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             level_next;
   logic             tick_next;

`ifdef TICK_DEBOUNCER_SYNC_EN
   logic [1:0] sync_ff;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_ff <= 2'b00;
      end else begin
         sync_ff <= {sync_ff[0], sw};
      end
   end

   assign sw_s = sync_ff[1];
`else
   assign sw_s = sw;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ZERO;
         cnt      <= '0;
         db_level <= 1'b0;
         db_tick  <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         db_level <= level_next;
         db_tick  <= tick_next;
      end
   end

   // The counter leaves its WAIT state on reaching CNT_LAST, so it can never
   // step past that value and never wraps.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      tick_next  = 1'b0;
      case (state)
         ZERO: begin
            if (sw_s) begin
               state_next = WAIT1;
               cnt_next   = '0;
            end
         end
         WAIT1: begin
            // A drop of the input wins over a coincident tick.
            if (!sw_s) begin
               state_next = ZERO;
            end else if (m_tick) begin
               if (cnt == CNT_LAST) begin
                  state_next = ONE;
                  tick_next  = 1'b1;
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end
         end
         ONE: begin
            if (!sw_s) begin
               state_next = WAIT0;
               cnt_next   = '0;
            end
         end
         WAIT0: begin
            // Bouncing back to ONE is not a new press: no pulse here.
            if (sw_s) begin
               state_next = ONE;
            end else if (m_tick) begin
               if (cnt == CNT_LAST) begin
                  state_next = ZERO;
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            state_next = ZERO;
            cnt_next   = '0;
         end
      endcase
      level_next = (state_next == ONE) || (state_next == WAIT0);
   end

endmodule
`default_nettype wire

// File: tb/tb_tick_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_debouncer
// Purpose  : Self-checking bench for tick_debouncer (CONFIRM_TICKS=3, m_tick
//            every 8 clocks on edges that are multiples of 8). Stimulus pushes
//            the expected output events (level changes and db_tick pulses,
//            with the exact clock edge they must appear on) into a queue; a
//            monitor pops and compares whenever an output event appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_debouncer;

`ifdef TICK_DEBOUNCER_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic m_tick = 1'b0;
   logic sw = 1'b1;
   logic db_level;
   logic db_tick;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int   kind;   // 0 = level change, 1 = db_tick pulse
      logic val;
      int   at;     // clock edge on which the event must appear
   } ev_t;

   ev_t q[$];

   tick_debouncer #(
      .CONFIRM_TICKS (3),
      .CNT_W         (8)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .m_tick   (m_tick),
      .sw       (sw),
      .db_level (db_level),
      .db_tick  (db_tick)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Edge of the 3rd tick strictly after edge w (the tick on w itself, if
   // any, is consumed while the FSM is still entering its WAIT state).
   function automatic int third_tick(input int w);
      return (w / 8 + 3) * 8;
   endfunction

   task automatic expect_rise(input int w);
      int r;
      r = third_tick(w);
      q.push_back('{0, 1'b1, r});
      q.push_back('{1, 1'b1, r});
   endtask

   task automatic expect_fall(input int w);
      q.push_back('{0, 1'b0, third_tick(w)});
   endtask

   task automatic chk(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %b required %b (cyc %0d)", name, act, req, cyc);
      end
   endtask

   // One clock: inputs change on the falling edge, then wait past the rising
   // edge; that rising edge is number cyc+1 at call time.
   task automatic clk1(input logic s, input logic t, input logic r);
      @(negedge clock);
      sw     = s;
      m_tick = t;
      reset  = r;
      @(posedge clock);
      #1;
   endtask

   task automatic run(input logic s, input int n);
      repeat (n) clk1(s, ((cyc + 1) % 8) == 0, 1'b0);
   endtask

   task automatic got(input int kind, input logic val);
      ev_t x;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event actual kind %0d val %b cyc %0d required none", kind, val, cyc);
      end else begin
         x = q.pop_front();
         if (x.kind != kind || x.val !== val || x.at != cyc) begin
            errors++;
            $display("FAIL event actual kind %0d val %b cyc %0d required kind %0d val %b cyc %0d",
                     kind, val, cyc, x.kind, x.val, x.at);
         end
      end
   endtask

   // Monitor: samples 2 time units after each rising edge.
   logic prev_level = 1'b0;
   initial begin
      forever begin
         @(posedge clock);
         #2;
         if (reset !== 1'b0) begin
            prev_level = db_level;
         end else begin
            if (db_level !== prev_level) got(0, db_level);
            if (db_tick === 1'b1) got(1, 1'b1);
            prev_level = db_level;
         end
      end
   end

   initial begin
      int e;
      logic s;

      @(posedge clock);
      #1;

      // Reset held 3 clocks with sw=1: outputs stay low.
      repeat (3) begin
         clk1(1'b1, 1'b0, 1'b1);
         chk("reset_level", db_level, 1'b0);
         chk("reset_tick", db_tick, 1'b0);
      end
      e = cyc + 1;
      expect_rise(e + LAT);
      run(1'b1, 40);

      // Release back to 0, then a clean press and release.
      e = cyc + 1;
      expect_fall(e + LAT);
      run(1'b0, 40);
      e = cyc + 1;
      expect_rise(e + LAT);
      run(1'b1, 100);
      e = cyc + 1;
      expect_fall(e + LAT);
      run(1'b0, 100);

      // Bounce: toggle every 5 clocks for 60 clocks, then settle high.
      s = 1'b0;
      for (int i = 0; i < 12; i++) begin
         s = ~s;
         run(s, 5);
      end
      e = cyc + 1;
      expect_rise(e + LAT);
      run(1'b1, 40);

      // Glitch while ONE: 12 clocks low cannot span 3 ticks.
      run(1'b0, 12);
      run(1'b1, 40);
      chk("glitch_level", db_level, 1'b1);

      // Back to ZERO for the priority case.
      e = cyc + 1;
      expect_fall(e + LAT);
      run(1'b0, 40);

      // Priority: WAIT1 with counter=2, sw_s drops on the same edge as a tick.
      clk1(1'b1, 1'b0, 1'b0);
      repeat (LAT) clk1(1'b1, 1'b0, 1'b0);
      clk1(1'b1, 1'b1, 1'b0);
      clk1(1'b1, 1'b1, 1'b0);
      repeat (LAT) clk1(1'b0, 1'b0, 1'b0);
      clk1(1'b0, 1'b1, 1'b0);
      run(1'b0, 20);
      chk("priority_level", db_level, 1'b0);

      // Reset in WAIT1 with counter=1; the next press needs a full 3 ticks.
      clk1(1'b1, 1'b0, 1'b0);
      repeat (LAT) clk1(1'b1, 1'b0, 1'b0);
      clk1(1'b1, 1'b1, 1'b0);
      repeat (2) begin
         clk1(1'b1, 1'b1, 1'b1);
         chk("midreset_level", db_level, 1'b0);
         chk("midreset_tick", db_tick, 1'b0);
      end
      e = cyc + 1;
      expect_rise(e + LAT);
      run(1'b1, 40);
      chk("final_level", db_level, 1'b1);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL missing_events actual %0d pending required 0", q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tick_debouncer.md
Name: tick_debouncer

Overview:
- Consumer end of the tick generator: takes the periodic single-cycle m_tick strobe and a raw mechanical switch/button input.
- Produces a debounced level and a one-cycle rising-edge pulse.
- Sits between board pins and the user logic, e.g. counters or FSMs stepped by button presses.
- Debounce time is measured in ticks, not clock cycles, so one tick generator can serve several debouncers.

Parameters:
- CONFIRM_TICKS, 3, number of m_tick strobes the input must stay stable before a level change is accepted (legal range 1..255).
- CNT_W, 8, width of the internal tick counter; must satisfy 2^CNT_W > CONFIRM_TICKS.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- m_tick  input  1  single-cycle strobe from the tick generator, synchronous to clock.
- sw  input  1  raw, bouncing switch input (asynchronous unless the sync feature is disabled).
- db_level  output  1  debounced switch level, registered.
- db_tick  output  1  one-cycle pulse on each accepted 0->1 transition, registered.

Behaviour:
- Reset (async, active-high): FSM=ZERO, counter=0, db_level=0, db_tick=0, sync flops=0. Reset mid-debounce aborts it; no db_tick is emitted.
- sw_s is the internal sampled switch: the synchronizer output, or sw directly (see Optional Feature).
- FSM states: ZERO, WAIT1, ONE, WAIT0; state register only.
- ZERO:
  - sw_s=1 -> WAIT1, counter cleared to 0.
  - otherwise stay.
- WAIT1:
  - sw_s=0 -> ZERO. This takes priority over a same-cycle m_tick.
  - sw_s=1 and m_tick=1 and counter==CONFIRM_TICKS-1 -> ONE.
  - sw_s=1 and m_tick=1 otherwise -> counter+1.
  - m_tick=0 -> hold.
- ONE:
  - sw_s=0 -> WAIT0, counter cleared to 0.
  - otherwise stay.
- WAIT0 (mirror of WAIT1):
  - sw_s=1 -> ONE (priority over m_tick).
  - sw_s=0 and m_tick=1 and counter==CONFIRM_TICKS-1 -> ZERO.
  - sw_s=0 and m_tick=1 otherwise -> counter+1.
- db_level: registered; 1 while the state is ONE or WAIT0, 0 while ZERO or WAIT1. It updates in the same edge as the state transition.
- db_tick:
  - Asserted for exactly one clock, on the same edge the FSM enters ONE from WAIT1.
  - Never asserted on a WAIT0->ONE bounce-back.
  - Never asserted on any falling transition.
- Counter: saturates at CONFIRM_TICKS-1 and never wraps. It is only ever compared for equality.
- Acceptance latency after sw_s becomes stable: between CONFIRM_TICKS-1 and CONFIRM_TICKS tick periods plus 1 clock, depending on tick phase. With CONFIRM_TICKS=1, the first m_tick after entering WAIT1 confirms.
- m_tick held high continuously (abuse case): each cycle counts as one tick; no lockup.

Optional Feature:
- Macro: TICK_DEBOUNCER_SYNC_EN.
- Defined: sw passes through a 2-flop synchronizer (both flops reset to 0) before sw_s. This adds 2 clocks of latency to every transition.
- Undefined: sw_s = sw directly. The caller guarantees sw is already synchronous to clock. Latency is reduced by 2 clocks; all other behaviour is identical.

Test Plan:
- Settings for all tests: CONFIRM_TICKS=3, m_tick driven by the bench every 8 clocks, sync feature enabled.
- Reset held 3 clocks with sw=1 -> db_level=0 and db_tick=0 during reset. After release, db_level rises after the 3rd m_tick following sw_s=1, with exactly one db_tick pulse.
- Clean press: sw 0->1 and held 100 clocks -> db_level=1 within 2+24+1 clocks of the sw edge, db_tick high exactly 1 clock. Release held 100 clocks -> db_level=0, no db_tick.
- Bounce: sw toggles every 5 clocks for 60 clocks, then settles at 1 -> no db_tick during the toggling. Exactly one db_tick after settling; db_level stays 1.
- Glitch during ONE: sw drops to 0 for 12 clocks (fewer than 3 ticks) -> db_level stays 1 and db_tick is not re-asserted.
- Priority: in WAIT1, drive sw_s=0 in the same cycle as m_tick=1 with counter=2 -> FSM returns to ZERO, db_level=0, no db_tick.
- Reset mid-WAIT1 (counter=1) -> state ZERO and counter 0 immediately. A later clean press needs a full 3 ticks to confirm.
